rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource among `NUM_REQUESTERS` requesters. Each cycle it selects at most one requester, starting the search just above the most recently granted index. A grant is held for as long as the owner keeps its request asserted, subject to an optional hold limit that forces rotation. Grants are registered one-hot, with a binary index and valid flag, and feed the resource's input mux and the requesters' handshake logic.

---
 rtl/rr_arbiter_if.sv | 25 ++
 rtl/rr_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the round-robin arbiter and its requesters.
// The arbiter side (master) drives the grant signals; requesters (slave) drive req.
interface rr_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int IDX_WIDTH      = $clog2(NUM_REQUESTERS)
);
  logic [NUM_REQUESTERS-1:0] req;
  logic [NUM_REQUESTERS-1:0] gnt;
  logic [IDX_WIDTH-1:0]      gnt_idx;
  logic                      gnt_valid;

  modport master (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

  modport slave (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold and optional forced rotation after MAX_HOLD cycles.
// All grant outputs are registered; a single search unit serves idle, release and expiry.
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int IDX_WIDTH      = $clog2(NUM_REQUESTERS),
  parameter int MAX_HOLD       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_if.master  arb
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_LIMIT;
  localparam logic [IDX_WIDTH-1:0] LAST_INIT = IDX_WIDTH'(NUM_REQUESTERS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [NUM_REQUESTERS-1:0] gnt_reg, gnt_next;
  logic [IDX_WIDTH-1:0]      gnt_idx_reg, gnt_idx_next;
  logic                      gnt_valid_reg, gnt_valid_next;
  logic [IDX_WIDTH-1:0]      last_reg, last_next;
  logic [HOLD_W-1:0]         hold_cnt_reg, hold_cnt_next;

  logic                      found;
  logic [IDX_WIDTH-1:0]      winner;
  logic [NUM_REQUESTERS-1:0] win_onehot;
  logic                      owner_req;
  logic                      expired;
  logic                      take;

  // Scan last+1 .. last+N; the previous owner is therefore considered last.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      idx = (int'(last_reg) + k) % NUM_REQUESTERS;
      if (!found && arb.req[idx]) begin
        found  = 1'b1;
        winner = IDX_WIDTH'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_onehot
    assign win_onehot[gi] = found && (winner == IDX_WIDTH'(gi));
  end

  assign owner_req = arb.req[gnt_idx_reg];
  assign expired   = (MAX_HOLD != 0) && (hold_cnt_reg >= HOLD_LIMIT);

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_valid_next = gnt_valid_reg;
    last_next      = last_reg;
    hold_cnt_next  = hold_cnt_reg;
    take           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (found) take = 1'b1;
      end
      GRANT: begin
        if (owner_req) begin
          // On expiry the owner competes again, but only after everyone above it.
          if (expired) take = 1'b1;
          else if (hold_cnt_reg != HOLD_SAT) hold_cnt_next = hold_cnt_reg + 1'b1;
        end else if (found) begin
          take = 1'b1;
        end else begin
          state_next     = IDLE;
          gnt_next       = '0;
          gnt_idx_next   = '0;
          gnt_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (take) begin
      state_next     = GRANT;
      gnt_next       = win_onehot;
      gnt_idx_next   = winner;
      gnt_valid_next = 1'b1;
      last_next      = winner;
      hold_cnt_next  = HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      last_reg      <= LAST_INIT;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_valid_reg <= gnt_valid_next;
      last_reg      <= last_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  assign arb.gnt       = gnt_reg;
  assign arb.gnt_idx   = gnt_idx_reg;
  assign arb.gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD=4 and unlimited) share one request stream;
// a queue-based reference model predicts every post-edge grant and a monitor compares.
module tb_rr_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [1:0]   idx;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_if #(.NUM_REQUESTERS(N)) bus4 ();
  rr_arbiter_if #(.NUM_REQUESTERS(N)) bus0 ();

  assign bus4.req = req;
  assign bus0.req = req;

  rr_arbiter #(.NUM_REQUESTERS(N), .MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .arb(bus4));
  rr_arbiter #(.NUM_REQUESTERS(N), .MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .arb(bus0));

  always #5 clk = ~clk;

  // Reference model state, index 0 -> dut4, index 1 -> dut0.
  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  int m_max   [2] = '{4, 0};
  exp_t q4 [$];
  exp_t q0 [$];
  exp_t e4, e0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d]  = N - 1;
      m_held[d]  = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [N-1:0] r);
    int   w;
    bit   regrant;
    exp_t e;
    w       = search(r, m_last[d]);
    regrant = 1'b0;
    if (m_owner[d] < 0) begin
      regrant = (w >= 0);
    end else if (r[m_owner[d]]) begin
      if (m_max[d] == 0 || m_held[d] < m_max[d]) m_held[d]++;
      else regrant = 1'b1;
    end else if (w >= 0) begin
      regrant = 1'b1;
    end else begin
      m_owner[d] = -1;
    end
    if (regrant) begin
      m_owner[d] = w;
      m_last[d]  = w;
      m_held[d]  = 1;
    end
    e.gnt = (m_owner[d] >= 0) ? N'(1 << m_owner[d]) : '0;
    e.idx = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'd0;
    e.v   = (m_owner[d] >= 0);
    if (d == 0) q4.push_back(e);
    else        q0.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [N-1:0] r);
    req = r;
    model_step(0, r);
    model_step(1, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " d4 gnt"},   bus4.gnt,       0);
    chk({tag, " d4 idx"},   bus4.gnt_idx,   0);
    chk({tag, " d4 valid"}, bus4.gnt_valid, 0);
    chk({tag, " d0 gnt"},   bus0.gnt,       0);
    chk({tag, " d0 valid"}, bus0.gnt_valid, 0);
  endtask

  // Monitor: one transaction per cycle, compared 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      chk("d4 gnt", bus4.gnt, e4.gnt);
      chk("d4 idx", bus4.gnt_idx, e4.idx);
      chk("d4 valid", bus4.gnt_valid, e4.v);
      $display("t=%0t req=%b d4 gnt=%b idx=%0d v=%b", $time, req, bus4.gnt, bus4.gnt_idx, bus4.gnt_valid);
    end
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("d0 gnt", bus0.gnt, e0.gnt);
      chk("d0 idx", bus0.gnt_idx, e0.idx);
      chk("d0 valid", bus0.gnt_valid, e0.v);
    end
    chk("d4 onehot", 32'($onehot0(bus4.gnt)), 1);
    chk("d4 valid_or", bus4.gnt_valid, |bus4.gnt);
    chk("d0 onehot", 32'($onehot0(bus0.gnt)), 1);
    chk("d0 valid_or", bus0.gnt_valid, |bus0.gnt);
  end

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check_cleared("async rst");
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] r;
    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();
    #1;
    check_cleared("rst t0");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_cleared("rst held");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // First grant after reset must go to requester 0.
    step(4'b1111);
    step(4'b0000);
    step(4'b0000);

    // Single requester held, then dropped.
    repeat (5) step(4'b0010);
    repeat (2) step(4'b0000);

    // Full contention.
    repeat (20) step(4'b1111);
    repeat (2) step(4'b0000);

    // Back-to-back handover.
    repeat (3) step(4'b0101);
    repeat (3) step(4'b0100);
    repeat (2) step(4'b0000);

    // Fairness after the top requester releases.
    repeat (2) step(4'b1000);
    repeat (10) step(4'b0011);
    repeat (2) step(4'b0000);

    // Sole requester across expiries.
    repeat (20) step(4'b1000);
    step(4'b0000);

    // Long contention between two requesters.
    repeat (100) step(4'b0011);

    // Async reset in the middle of a grant, then a fresh arbitration.
    reset_pulse();
    repeat (3) step(4'b0110);
    repeat (2) step(4'b0000);

    // Randomized traffic with sticky requests and occasional resets.
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom());
      if ($urandom_range(0, 79) == 0) reset_pulse();
      step(r);
    end
    step(4'b0000);

    @(posedge clk);
    #2;
    chk("queue drained", q4.size() + q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
